w5100s_burst_access: RTL
========================

// Module: w5100s_burst_access
// PURPOSE
//  Upstream command engine for the W5100S SPI master. Turns one multi-byte register
//  access request (start address + length) into a sequence of single-byte SPI frames.
//  Auto-increments the address per byte, streams write bytes in and read bytes out,
//  and signals completion. Sits between the socket/init control FSMs and the SPI master.
// PARAMETERS
//  LEN_W          8     width of cmd_len; a burst is 1..2^LEN_W-1 bytes
//  GAP_CYCLES     2     idle clk cycles between consecutive SPI frames (>=1)
//  TIMEOUT_CYCLES 4096  per-frame watchdog limit (used only with W5100S_BA_TIMEOUT_EN)
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      asynchronous reset, active-low
//  cmd_valid       in   1      command request
//  cmd_ready       out  1      high only in IDLE; command accepted on valid&&ready
//  cmd_write       in   1      1=register write, 0=register read
//  cmd_addr        in   16     start register address
//  cmd_len         in   LEN_W  byte count
//  wr_data         in   8      write byte stream
//  wr_valid        in   1      write byte available
//  wr_ready        out  1      high in FETCH; byte taken on wr_valid&&wr_ready
//  rd_data         out  8      read byte
//  rd_valid        out  1      1-cycle pulse per read byte, no backpressure
//  done            out  1      1-cycle pulse at end of burst (also after an abort)
//  err             out  1      1-cycle pulse with done when burst aborted by timeout
//  active          out  1      high from command accept until done pulse
//  spi_start       out  1      1-cycle frame start pulse to SPI master
//  spi_write_read  out  1      frame direction, held stable while frame in flight
//  spi_data_in     out  24     {addr[15:0], wdata[7:0]}; wdata=8'h00 for reads
//  spi_data_out    in   8      read byte from SPI master
//  spi_busy        in   1      SPI master busy
//  spi_data_ready  in   1      SPI master frame complete (level, held until next start)
// BEHAVIOUR
//  Reset: all outputs 0, rd_data=8'h00, spi_data_in=24'h0, state IDLE. Reset mid-burst
//   aborts immediately: no done/err pulse, spi_start low from the reset edge onward.
//  States: IDLE -> (write) FETCH -> ISSUE -> WAIT_ACK -> WAIT_DONE -> GAP -> next/FINISH.
//  IDLE: latch cmd on cmd_valid; cmd_len==0 -> FINISH directly (done, no SPI frame).
//  FETCH (write only): wr_ready=1; on wr_valid capture byte -> ISSUE. Stall indefinitely.
//  ISSUE: spi_start=1 for exactly 1 cycle, spi_data_in/spi_write_read already valid.
//  WAIT_ACK: wait spi_busy==1 && spi_data_ready==0 (stale ready ignored).
//  WAIT_DONE: wait spi_data_ready==1 -> GAP.
//  GAP: first cycle, for reads, rd_data<=spi_data_out, rd_valid=1 next cycle. Stay
//   GAP_CYCLES; addr<=addr+1 (16-bit wrap FFFF->0000), remaining-1; remaining==0 ->
//   FINISH, else FETCH (write) / ISSUE (read).
//  FINISH: done=1 for 1 cycle, active falls same edge, -> IDLE (cmd_ready next cycle).
//  Latency read len1: spi_start 1 cycle after accept; rd_valid 2 cycles after ready seen.
//  Input cmd fields ignored outside IDLE; spi_* outputs stable while not in ISSUE.
// CONFIGURATION
//  W5100S_BA_TIMEOUT_EN defined: counter runs in WAIT_ACK+WAIT_DONE, cleared in ISSUE;
//   reaching TIMEOUT_CYCLES aborts remaining bytes -> FINISH with err=1 and done=1.
//  Not defined: no counter, waits forever, err tied 0.
// TESTING
//  write len1 addr 0x0123 wr_data 0xAB -> one spi_start, spi_data_in=0x0123AB, wr=1, done
//  read len4 addr 0x0010, model returns 11,22,33,44 -> addrs 0010..0013, rd_valid x4 same order
//  write len3 addr 0xFFFE -> spi_data_in addrs FFFE, FFFF, 0000; one done pulse
//  wr_valid low 20 cycles mid-burst -> no spi_start while stalled; resumes on wr_valid
//  cmd_len=0 -> done 1 cycle after accept, no spi_start; model never busy (TIMEOUT_EN) ->
//   err+done TIMEOUT_CYCLES after spi_start
//  rst_n low during WAIT_DONE of 2nd byte -> all outputs reset, no done; new cmd works

Source files
------------

// File: rtl/w5100s_burst_access.sv
// w5100s_burst_access: turns one multi-byte W5100S register access (start address +
// length) into a sequence of single-byte SPI frames, auto-incrementing the address.
// Latency: first spi_start one cycle after command accept; read byte out two cycles
//   after the SPI master reports frame complete.
// Backpressure: cmd_ready only in IDLE; the write stream stalls indefinitely in FETCH;
//   rd_valid has no backpressure.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/len  burst request (accepted on valid && ready, IDLE only)
//   wr_data/wr_valid/wr_ready   write byte stream (taken in FETCH)
//   rd_data/rd_valid            read byte stream (1-cycle pulse per byte)
//   done/err/active             burst status (err pulses with done on watchdog abort)
//   spi_start/spi_write_read/spi_data_in   frame request to the SPI master
//   spi_data_out/spi_busy/spi_data_ready   frame status/result from the SPI master
//
// Optional feature: define W5100S_BA_TIMEOUT_EN to enable a per-frame watchdog that
// aborts the burst (done + err) when a frame does not complete within TIMEOUT_CYCLES.
// Without it the engine waits forever and err is tied low.

module w5100s_burst_access #(
  parameter int LEN_W          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             active,
  output logic             spi_start,
  output logic             spi_write_read,
  output logic [23:0]      spi_data_in,
  input  logic [7:0]       spi_data_out,
  input  logic             spi_busy,
  input  logic             spi_data_ready
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t           state;
  logic             is_write;
  logic [15:0]      addr;
  logic [LEN_W-1:0] remaining;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      addr_inc;

  // 16-bit natural wrap FFFF -> 0000
  assign addr_inc = addr + 16'd1;

`ifdef W5100S_BA_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort edge chosen so done/err appear TIMEOUT_CYCLES cycles after the spi_start
  // cycle: the counter is 0 in the first WAIT_ACK cycle (one after spi_start).
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      is_write       <= 1'b0;
      addr           <= 16'h0000;
      remaining      <= '0;
      gap_cnt        <= '0;
      cmd_ready      <= 1'b0;
      wr_ready       <= 1'b0;
      rd_data        <= 8'h00;
      rd_valid       <= 1'b0;
      done           <= 1'b0;
      active         <= 1'b0;
      spi_start      <= 1'b0;
      spi_write_read <= 1'b0;
      spi_data_in    <= 24'h000000;
`ifdef W5100S_BA_TIMEOUT_EN
      to_cnt         <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      // single-cycle pulses
      spi_start <= 1'b0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
`ifdef W5100S_BA_TIMEOUT_EN
      err_q     <= 1'b0;
`endif

      case (state)
        S_IDLE: begin
          // cmd_ready comes up one cycle after reset release, then stays up in IDLE
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            active    <= 1'b1;
            is_write  <= cmd_write;
            addr      <= cmd_addr;
            remaining <= cmd_len;
            if (cmd_len == '0) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else if (cmd_write) begin
              wr_ready <= 1'b1;
              state    <= S_FETCH;
            end else begin
              spi_start      <= 1'b1;
              spi_write_read <= 1'b0;
              spi_data_in    <= {cmd_addr, 8'h00};
              state          <= S_ISSUE;
            end
          end
        end

        S_FETCH: begin
          if (wr_valid) begin
            wr_ready       <= 1'b0;
            spi_start      <= 1'b1;
            spi_write_read <= 1'b1;
            spi_data_in    <= {addr, wr_data};
            state          <= S_ISSUE;
          end
        end

        // spi_start is high for exactly this cycle
        S_ISSUE: begin
          state <= S_WAIT_ACK;
`ifdef W5100S_BA_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end

        // a data_ready left over from the previous frame must not count as completion
        S_WAIT_ACK: begin
          if (spi_busy && !spi_data_ready) state <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (spi_data_ready) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          // data_ready is a held level, so spi_data_out is still valid here
          if ((gap_cnt == '0) && !is_write) begin
            rd_data  <= spi_data_out;
            rd_valid <= 1'b1;
          end
          if (gap_cnt == GAP_LAST) begin
            addr      <= addr_inc;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else if (is_write) begin
              wr_ready <= 1'b1;
              state    <= S_FETCH;
            end else begin
              spi_start      <= 1'b1;
              spi_write_read <= 1'b0;
              spi_data_in    <= {addr_inc, 8'h00};
              state          <= S_ISSUE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        // done is high during this cycle; active drops as done drops
        S_FINISH: begin
          active    <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

`ifdef W5100S_BA_TIMEOUT_EN
      // watchdog overrides any normal progress from the wait states
      if ((state == S_WAIT_ACK) || (state == S_WAIT_DONE)) begin
        if (to_cnt == TO_LAST) begin
          done  <= 1'b1;
          err_q <= 1'b1;
          state <= S_FINISH;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
`endif
    end
  end

endmodule
